mem_write_checker: RTL and testbench

//  Synthesizable self-check monitor for the processor data-memory write port (MemWrite/DataAdr/WriteData).

---
 rtl/mem_write_checker_pkg.sv | 24 ++
 rtl/mem_write_checker_if.sv | 15 +
 rtl/mem_write_checker_sat_counter.sv | 38 +++
 rtl/mem_write_checker.sv | 198 +++++++++++++++++++
 tb/tb_mem_write_checker.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_write_checker_pkg.sv
// Shared types for the data-memory write checker: FSM states, verdict codes
// and a helper that keeps index ports at least one bit wide.
package memchk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_PASS = 3'd2,
    ST_FAIL = 3'd3,
    ST_TMO  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    FC_NONE     = 2'd0,
    FC_MISMATCH = 2'd1,
    FC_TIMEOUT  = 2'd2
  } fail_code_t;

  // A one-entry table still needs a real index port, so never go below 1 bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_write_checker_if.sv
// Processor data-memory write port as seen by the checker: the core drives
// it (master), the checker only observes it (slave).
interface mem_write_checker_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              MemWrite;
  logic [ADDR_W-1:0] DataAdr;
  logic [DATA_W-1:0] WriteData;

  modport master (output MemWrite, DataAdr, WriteData);
  modport slave  (input  MemWrite, DataAdr, WriteData);

endinterface

// File: rtl/mem_write_checker_sat_counter.sv
// Saturating up-counter with synchronous clear and count enable; the count
// sticks at MAX instead of wrapping.
module sat_counter #(
  parameter int W   = 8,
  parameter int MAX = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_d;
  logic [W-1:0] count_q;

  // Next count: clear wins over enable, and enable stops at the ceiling.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != W'(MAX))) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/mem_write_checker.sv
// Self-check monitor for the processor data-memory write port. Stores seen
// while running must hit a loaded table of (address, data) pairs in order;
// stores into a scratch window are skipped. Reports a registered
// PASS / FAIL / TIMEOUT verdict held until clear or reset.
module mem_write_checker
  import memchk_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter int              DATA_W   = 32,
  parameter int              N_EXPECT = 4,
  parameter int              TIMEOUT  = 64,
  parameter logic [ADDR_W-1:0] IGN_BASE = ADDR_W'('h60),
  parameter logic [ADDR_W-1:0] IGN_MASK = ~ADDR_W'(3),
  parameter int              IDX_W    = idx_width(N_EXPECT),
  parameter int              CNT_W    = $clog2(TIMEOUT + 1),
  parameter int              MC_W     = $clog2(N_EXPECT + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              start,
  input  logic              clear,
  mem_write_checker_if.slave mem,
  output logic              done,
  output logic              pass,
  output logic [1:0]        fail_code,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [MC_W-1:0]   match_count
);

  state_t            state_d,       state_q;
  fail_code_t        fail_code_d,   fail_code_q;
  logic [ADDR_W-1:0] fail_addr_d,   fail_addr_q;
  logic [DATA_W-1:0] fail_data_d,   fail_data_q;
  logic [MC_W-1:0]   match_count_d, match_count_q;
  logic              done_d,        done_q;
  logic              pass_d,        pass_q;

  logic [ADDR_W-1:0] exp_addr_d [N_EXPECT];
  logic [ADDR_W-1:0] exp_addr_q [N_EXPECT];
  logic [DATA_W-1:0] exp_data_d [N_EXPECT];
  logic [DATA_W-1:0] exp_data_q [N_EXPECT];

  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_data;
  logic              store_match;
  logic              store_ignored;
  logic              cnt_en;
  logic              cnt_clr;
  logic [CNT_W-1:0]  cycle_cnt;

  // Cycles spent in RUN; cleared on the start edge, frozen outside RUN.
  sat_counter #(
    .W   (CNT_W),
    .MAX (TIMEOUT)
  ) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (cnt_en),
    .clr   (cnt_clr),
    .count (cycle_cnt)
  );

  // Table loading is only possible while idle; out-of-range indices match no entry.
  always_comb begin
    exp_addr_d = exp_addr_q;
    exp_data_d = exp_data_q;
    if ((state_q == ST_IDLE) && cfg_we) begin
      for (int i = 0; i < N_EXPECT; i++) begin
        if (cfg_idx == IDX_W'(i)) begin
          exp_addr_d[i] = cfg_addr;
          exp_data_d[i] = cfg_data;
        end
      end
    end
  end

  // Select the table entry the next store has to match.
  always_comb begin
    cur_addr = '0;
    cur_data = '0;
    for (int i = 0; i < N_EXPECT; i++) begin
      if (match_count_q == MC_W'(i)) begin
        cur_addr = exp_addr_q[i];
        cur_data = exp_data_q[i];
      end
    end
    store_match   = (mem.DataAdr == cur_addr) && (mem.WriteData == cur_data);
    store_ignored = ((mem.DataAdr & IGN_MASK) == IGN_BASE);
  end

  // Verdict FSM: a store decision is taken first, and only a cycle that is
  // still undecided may turn into a timeout, so PASS and FAIL beat TIMEOUT.
  always_comb begin
    state_d       = state_q;
    fail_code_d   = fail_code_q;
    fail_addr_d   = fail_addr_q;
    fail_data_d   = fail_data_q;
    match_count_d = match_count_q;
    cnt_en        = 1'b0;
    cnt_clr       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d       = ST_RUN;
          match_count_d = '0;
          fail_code_d   = FC_NONE;
          fail_addr_d   = '0;
          fail_data_d   = '0;
          cnt_clr       = 1'b1;
        end
      end

      ST_RUN: begin
        cnt_en = 1'b1;
        if (mem.MemWrite) begin
          if (store_match) begin
            match_count_d = match_count_q + MC_W'(1);
            if (match_count_q == MC_W'(N_EXPECT - 1)) begin
              state_d = ST_PASS;
            end
          end else if (!store_ignored) begin
            state_d     = ST_FAIL;
            fail_code_d = FC_MISMATCH;
            fail_addr_d = mem.DataAdr;
            fail_data_d = mem.WriteData;
          end
        end
        if ((state_d == ST_RUN) && (cycle_cnt == CNT_W'(TIMEOUT - 1))) begin
          state_d     = ST_TMO;
          fail_code_d = FC_TIMEOUT;
        end
      end

      ST_PASS, ST_FAIL, ST_TMO: begin
        if (clear) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    done_d = (state_d == ST_PASS) || (state_d == ST_FAIL) || (state_d == ST_TMO);
    pass_d = (state_d == ST_PASS);
  end

  // Expected-store table registers; reset wipes every entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_EXPECT; i++) begin
        exp_addr_q[i] <= '0;
        exp_data_q[i] <= '0;
      end
    end else begin
      exp_addr_q <= exp_addr_d;
      exp_data_q <= exp_data_d;
    end
  end

  // FSM state and registered verdict outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      fail_code_q   <= FC_NONE;
      fail_addr_q   <= '0;
      fail_data_q   <= '0;
      match_count_q <= '0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      fail_code_q   <= fail_code_d;
      fail_addr_q   <= fail_addr_d;
      fail_data_q   <= fail_data_d;
      match_count_q <= match_count_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
    end
  end

  assign done        = done_q;
  assign pass        = pass_q;
  assign fail_code   = fail_code_q;
  assign fail_addr   = fail_addr_q;
  assign fail_data   = fail_data_q;
  assign cycle_count = cycle_cnt;
  assign match_count = match_count_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// Bench for mem_write_checker: a one-entry checker driven from a vector table
// plus hand-written timeout / tie-break / reset sequences, and a two-entry
// checker for ordered matching.
module tb_mem_write_checker;

  // One table-driven step for the one-entry checker.
  // op: 0 plain cycle, 1 start pulse, 2 clear pulse.
  typedef struct {
    logic [1:0]  op;
    logic        mw;
    logic [31:0] addr;
    logic [31:0] data;
    logic        chk_all;
    logic        e_done;
    logic        e_pass;
    logic [1:0]  e_fc;
    logic [31:0] e_fa;
    logic [31:0] e_fd;
    logic [6:0]  e_cc;
    logic        e_mc;
  } vec_t;

  logic clk;
  logic reset;

  logic        d1_cfg_we, d2_cfg_we;
  logic        d1_cfg_idx, d2_cfg_idx;
  logic [31:0] d1_cfg_addr, d1_cfg_data, d2_cfg_addr, d2_cfg_data;
  logic        d1_start, d1_clear, d2_start, d2_clear;

  logic        d1_done, d1_pass, d2_done, d2_pass;
  logic [1:0]  d1_fc, d2_fc;
  logic [31:0] d1_fa, d1_fd, d2_fa, d2_fd;
  logic [6:0]  d1_cc, d2_cc;
  logic        d1_mc;
  logic [1:0]  d2_mc;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  mem_write_checker_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
  mem_write_checker_if #(.ADDR_W(32), .DATA_W(32)) bus2 ();

  mem_write_checker #(.N_EXPECT(1)) dut1 (
    .clk(clk), .reset(reset),
    .cfg_we(d1_cfg_we), .cfg_idx(d1_cfg_idx), .cfg_addr(d1_cfg_addr), .cfg_data(d1_cfg_data),
    .start(d1_start), .clear(d1_clear), .mem(bus1),
    .done(d1_done), .pass(d1_pass), .fail_code(d1_fc), .fail_addr(d1_fa), .fail_data(d1_fd),
    .cycle_count(d1_cc), .match_count(d1_mc)
  );

  mem_write_checker #(.N_EXPECT(2)) dut2 (
    .clk(clk), .reset(reset),
    .cfg_we(d2_cfg_we), .cfg_idx(d2_cfg_idx), .cfg_addr(d2_cfg_addr), .cfg_data(d2_cfg_data),
    .start(d2_start), .clear(d2_clear), .mem(bus2),
    .done(d2_done), .pass(d2_pass), .fail_code(d2_fc), .fail_addr(d2_fa), .fail_data(d2_fd),
    .cycle_count(d2_cc), .match_count(d2_mc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mkv(input logic [1:0] op, input logic mw, input logic [31:0] addr,
                               input logic [31:0] data, input logic chk_all, input logic e_done,
                               input logic e_pass, input logic [1:0] e_fc, input logic [31:0] e_fa,
                               input logic [31:0] e_fd, input logic [6:0] e_cc, input logic e_mc);
    vec_t v;
    v.op = op; v.mw = mw; v.addr = addr; v.data = data; v.chk_all = chk_all;
    v.e_done = e_done; v.e_pass = e_pass; v.e_fc = e_fc; v.e_fa = e_fa; v.e_fd = e_fd;
    v.e_cc = e_cc; v.e_mc = e_mc;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleTicks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic store1(input logic [31:0] a, input logic [31:0] d);
    bus1.MemWrite = 1'b1; bus1.DataAdr = a; bus1.WriteData = d;
    tick();
    bus1.MemWrite = 1'b0;
  endtask

  task automatic store2(input logic [31:0] a, input logic [31:0] d);
    bus2.MemWrite = 1'b1; bus2.DataAdr = a; bus2.WriteData = d;
    tick();
    bus2.MemWrite = 1'b0;
  endtask

  task automatic pulse1(input logic s, input logic c);
    d1_start = s; d1_clear = c;
    tick();
    d1_start = 1'b0; d1_clear = 1'b0;
  endtask

  task automatic pulse2(input logic s, input logic c);
    d2_start = s; d2_clear = c;
    tick();
    d2_start = 1'b0; d2_clear = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v, input int n);
    d1_start = (v.op == 2'd1);
    d1_clear = (v.op == 2'd2);
    bus1.MemWrite = v.mw; bus1.DataAdr = v.addr; bus1.WriteData = v.data;
    tick();
    d1_start = 1'b0; d1_clear = 1'b0; bus1.MemWrite = 1'b0;
    checkOutput($sformatf("vec%0d done", n), d1_done, v.e_done);
    checkOutput($sformatf("vec%0d pass", n), d1_pass, v.e_pass);
    if (v.chk_all) begin
      checkOutput($sformatf("vec%0d fail_code", n), d1_fc, v.e_fc);
      checkOutput($sformatf("vec%0d fail_addr", n), d1_fa, v.e_fa);
      checkOutput($sformatf("vec%0d fail_data", n), d1_fd, v.e_fd);
      checkOutput($sformatf("vec%0d cycle_count", n), d1_cc, v.e_cc);
      checkOutput($sformatf("vec%0d match_count", n), d1_mc, v.e_mc);
    end
  endtask

  initial begin
    reset = 1'b1;
    d1_cfg_we = 0; d1_cfg_idx = 0; d1_cfg_addr = 0; d1_cfg_data = 0; d1_start = 0; d1_clear = 0;
    d2_cfg_we = 0; d2_cfg_idx = 0; d2_cfg_addr = 0; d2_cfg_data = 0; d2_start = 0; d2_clear = 0;
    bus1.MemWrite = 0; bus1.DataAdr = 0; bus1.WriteData = 0;
    bus2.MemWrite = 0; bus2.DataAdr = 0; bus2.WriteData = 0;

    //          op mw addr  data chk done pass fc fa   fd cc mc
    vecs.push_back(mkv(1, 0, 0,    0, 1, 0, 0, 0, 0,   0, 0, 0)); // start
    vecs.push_back(mkv(0, 1, 96,   3, 1, 0, 0, 0, 0,   0, 1, 0)); // scratch window
    vecs.push_back(mkv(0, 1, 100,  7, 1, 1, 1, 0, 0,   0, 2, 1)); // final match
    vecs.push_back(mkv(0, 1, 5,    5, 1, 1, 1, 0, 0,   0, 2, 1)); // store after verdict ignored
    vecs.push_back(mkv(2, 0, 0,    0, 0, 0, 0, 0, 0,   0, 0, 0)); // clear
    vecs.push_back(mkv(1, 0, 0,    0, 1, 0, 0, 0, 0,   0, 0, 0)); // start
    vecs.push_back(mkv(0, 1, 104,  7, 1, 1, 0, 1, 104, 7, 1, 0)); // wrong address
    vecs.push_back(mkv(0, 1, 100,  7, 1, 1, 0, 1, 104, 7, 1, 0)); // frozen after FAIL
    vecs.push_back(mkv(1, 0, 0,    0, 1, 1, 0, 1, 104, 7, 1, 0)); // start outside IDLE ignored
    vecs.push_back(mkv(2, 0, 0,    0, 0, 0, 0, 0, 0,   0, 0, 0)); // clear
    vecs.push_back(mkv(1, 0, 0,    0, 1, 0, 0, 0, 0,   0, 0, 0)); // start clears fail_*
    vecs.push_back(mkv(0, 1, 'h61, 1, 1, 0, 0, 0, 0,   0, 1, 0)); // window, low bits masked
    vecs.push_back(mkv(0, 0, 104,  7, 1, 0, 0, 0, 0,   0, 2, 0)); // no strobe
    vecs.push_back(mkv(0, 1, 100,  8, 1, 1, 0, 1, 100, 8, 3, 0)); // wrong data
    vecs.push_back(mkv(2, 0, 0,    0, 0, 0, 0, 0, 0,   0, 0, 0));
    vecs.push_back(mkv(1, 0, 0,    0, 1, 0, 0, 0, 0,   0, 0, 0));
    vecs.push_back(mkv(0, 1, 92,   7, 1, 1, 0, 1, 92,  7, 1, 0)); // just below window
    vecs.push_back(mkv(2, 0, 0,    0, 0, 0, 0, 0, 0,   0, 0, 0));
    vecs.push_back(mkv(1, 1, 100,  7, 1, 0, 0, 0, 0,   0, 0, 0)); // store on start edge ignored
    vecs.push_back(mkv(0, 1, 'h63, 0, 1, 0, 0, 0, 0,   0, 1, 0)); // top of window
    vecs.push_back(mkv(0, 1, 100,  7, 1, 1, 1, 0, 0,   0, 2, 1));
    vecs.push_back(mkv(2, 0, 0,    0, 0, 0, 0, 0, 0,   0, 0, 0));

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("reset done", d1_done, 0);
    checkOutput("reset pass", d1_pass, 0);
    checkOutput("reset fail_code", d1_fc, 0);
    checkOutput("reset cycle_count", d1_cc, 0);
    checkOutput("reset match_count", d2_mc, 0);

    // Load tables; index 1 is out of range for the one-entry checker.
    d1_cfg_we = 1; d1_cfg_idx = 0; d1_cfg_addr = 100; d1_cfg_data = 7;
    d2_cfg_we = 1; d2_cfg_idx = 0; d2_cfg_addr = 100; d2_cfg_data = 7;
    tick();
    d1_cfg_idx = 1; d1_cfg_addr = 300; d1_cfg_data = 300;
    d2_cfg_idx = 1; d2_cfg_addr = 84;  d2_cfg_data = 25;
    tick();
    d1_cfg_we = 0; d2_cfg_we = 0;

    foreach (vecs[i]) applyStimulus(vecs[i], i);

    // Silent run times out on the 64th RUN cycle, then stays frozen.
    pulse1(1, 0);
    idleTicks(63);
    checkOutput("tmo not yet done", d1_done, 0);
    checkOutput("tmo cycle_count 63", d1_cc, 63);
    tick();
    checkOutput("tmo done", d1_done, 1);
    checkOutput("tmo pass", d1_pass, 0);
    checkOutput("tmo fail_code", d1_fc, 2);
    checkOutput("tmo cycle_count", d1_cc, 64);
    idleTicks(3);
    checkOutput("tmo held cycle_count", d1_cc, 64);
    checkOutput("tmo held fail_code", d1_fc, 2);
    pulse1(0, 1);

    // Final match on the 64th cycle beats the timeout.
    pulse1(1, 0);
    idleTicks(63);
    store1(100, 7);
    checkOutput("race pass", d1_pass, 1);
    checkOutput("race fail_code", d1_fc, 0);
    checkOutput("race cycle_count", d1_cc, 64);
    pulse1(0, 1);

    // Mismatch on the 64th cycle also beats the timeout.
    pulse1(1, 0);
    idleTicks(63);
    store1(8, 8);
    checkOutput("race mismatch fail_code", d1_fc, 1);
    checkOutput("race mismatch fail_addr", d1_fa, 8);
    pulse1(0, 1);

    // Table writes while running are dropped.
    pulse1(1, 0);
    d1_cfg_we = 1; d1_cfg_idx = 0; d1_cfg_addr = 200; d1_cfg_data = 200;
    tick();
    d1_cfg_we = 0;
    store1(100, 7);
    checkOutput("cfg in run pass", d1_pass, 1);
    pulse1(0, 1);

    // Two-entry table: order matters.
    pulse2(1, 0);
    store2(84, 25);
    checkOutput("order fail_code", d2_fc, 1);
    checkOutput("order fail_addr", d2_fa, 84);
    checkOutput("order fail_data", d2_fd, 25);
    checkOutput("order match_count", d2_mc, 0);
    pulse2(0, 1);
    pulse2(1, 0);
    store2(100, 7);
    checkOutput("two first match_count", d2_mc, 1);
    checkOutput("two first done", d2_done, 0);
    store2(96, 9);
    checkOutput("two window match_count", d2_mc, 1);
    store2(84, 25);
    checkOutput("two pass", d2_pass, 1);
    checkOutput("two match_count", d2_mc, 2);
    checkOutput("two fail_code", d2_fc, 0);
    pulse2(0, 1);

    // Asynchronous reset mid-cycle clears verdicts and tables at once.
    d1_start = 1; d2_start = 1;
    tick();
    d1_start = 0; d2_start = 0;
    bus2.MemWrite = 1; bus2.DataAdr = 100; bus2.WriteData = 7;
    store1(100, 7);
    bus2.MemWrite = 0;
    checkOutput("pre-reset pass", d1_pass, 1);
    checkOutput("pre-reset match_count", d2_mc, 1);
    #2 reset = 1'b1;
    #1;
    checkOutput("async pass", d1_pass, 0);
    checkOutput("async done", d1_done, 0);
    checkOutput("async match_count d1", d1_mc, 0);
    checkOutput("async cycle_count", d2_cc, 0);
    checkOutput("async match_count d2", d2_mc, 0);
    #2 reset = 1'b0;
    d1_start = 1; d2_start = 1;
    tick();
    d1_start = 0; d2_start = 0;
    bus2.MemWrite = 1; bus2.DataAdr = 0; bus2.WriteData = 0;
    store1(0, 0);
    bus2.MemWrite = 0;
    checkOutput("cleared table pass d1", d1_pass, 1);
    checkOutput("cleared table match d2", d2_mc, 1);
    store2(0, 0);
    checkOutput("cleared table pass d2", d2_pass, 1);
    checkOutput("cleared table match_count d2", d2_mc, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
